// File: rtl/subckt_pattern_driver.sv
// rtl/subckt_pattern_driver.sv - LFSR stimulus generator and MISR response compactor (optional: SIG_COMPARE_EN)
module subckt_pattern_driver #(
  parameter int                   LFSR_W    = 16,
  parameter logic [LFSR_W-1:0]    LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0]    SEED      = 16'hACE1,
  parameter int                   MISR_W    = 16,
  parameter logic [MISR_W-1:0]    MISR_TAPS = 16'h002D,
  parameter int                   PAT_CNT_W = 10,
  parameter int                   RESP_LAT  = 1
) (
  input  logic                 I1470_clk,
  input  logic                 I1477_rst,
  input  logic                 start,
  input  logic [PAT_CNT_W-1:0] num_pat,
  output logic [3:0]           stim_out,
  input  logic                 resp_in,
  output logic                 busy,
  output logic                 done,
  output logic [PAT_CNT_W-1:0] pat_idx,
  output logic [MISR_W-1:0]    signature
`ifdef SIG_COMPARE_EN
  ,
  input  logic [MISR_W-1:0]    exp_sig,
  output logic                 pass,
  output logic                 fail
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [LFSR_W-1:0]    SEED_EFF   = (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;
  localparam logic [2:0]           DRAIN_LAST = 3'(RESP_LAT);
  localparam logic [PAT_CNT_W-1:0] PAT_ONE    = {{(PAT_CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [LFSR_W-1:0]      lfsr_q, lfsr_d;
  logic [MISR_W-1:0]      sig_q, sig_d;
  logic [PAT_CNT_W-1:0]   pat_q, pat_d;
  logic [PAT_CNT_W-1:0]   num_q, num_d;
  logic [2:0]             drain_q, drain_d;
  logic [RESP_LAT-1:0]    vpipe_q, vpipe_d;
  logic                   push_valid;
  logic                   sample_en;

  // The response for a pattern arrives RESP_LAT cycles after it was applied.
  assign sample_en = vpipe_q[RESP_LAT-1];

  // Next-state, sequencing and datapath updates.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    sig_d      = sig_q;
    pat_d      = pat_q;
    num_d      = num_q;
    drain_d    = drain_q;
    push_valid = 1'b0;

    if (sample_en) begin
      sig_d = {sig_q[MISR_W-2:0], 1'b0}
            ^ (sig_q[MISR_W-1] ? MISR_TAPS : '0)
            ^ {{(MISR_W-1){1'b0}}, resp_in};
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d   = num_pat;
          lfsr_d  = SEED_EFF;
          sig_d   = '0;
          pat_d   = '0;
          drain_d = '0;
          state_d = (num_pat == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        push_valid = 1'b1;
        lfsr_d     = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        if (pat_q == num_q - PAT_ONE) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          pat_d = pat_q + PAT_ONE;
        end
      end
      S_DRAIN: begin
        // An empty run has nothing in flight and leaves after one cycle.
        if ((num_q == '0) || (drain_q == DRAIN_LAST)) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    vpipe_d[0] = push_valid;
    for (int i = 1; i < RESP_LAT; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end
  end

  // State and datapath registers.
  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= '0;
      sig_q   <= '0;
      pat_q   <= '0;
      num_q   <= '0;
      drain_q <= '0;
      vpipe_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      sig_q   <= sig_d;
      pat_q   <= pat_d;
      num_q   <= num_d;
      drain_q <= drain_d;
      vpipe_q <= vpipe_d;
    end
  end

  assign stim_out  = (state_q == S_RUN) ? lfsr_q[3:0] : 4'h0;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign pat_idx   = pat_q;
  assign signature = sig_q;

`ifdef SIG_COMPARE_EN
  logic [MISR_W-1:0] exp_q;
  logic              pass_q;
  logic              fail_q;

  // Verdict is captured on entry to DONE so it is visible during the done pulse.
  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      exp_q  <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if ((state_q == S_IDLE) && start) begin
      exp_q  <= exp_sig;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else if ((state_q == S_DRAIN) && (state_d == S_DONE)) begin
      pass_q <= (sig_d == exp_q);
      fail_q <= (sig_d != exp_q);
    end
  end

  assign pass = pass_q;
  assign fail = fail_q;
`endif

endmodule

// File: tb/tb_subckt_pattern_driver.sv
// tb/tb_subckt_pattern_driver.sv - self-checking bench for subckt_pattern_driver
module tb_subckt_pattern_driver;

  localparam int RL = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  num_pat = '0;
  logic        resp_in = 1'b0;
  logic [3:0]  stim_out;
  logic        busy;
  logic        done;
  logic [9:0]  pat_idx;
  logic [15:0] signature;
`ifdef SIG_COMPARE_EN
  logic [15:0] exp_sig = '0;
  logic        pass;
  logic        fail;
`endif

  subckt_pattern_driver dut (
    .I1470_clk (clk),
    .I1477_rst (rst_n),
    .start     (start),
    .num_pat   (num_pat),
    .stim_out  (stim_out),
    .resp_in   (resp_in),
    .busy      (busy),
    .done      (done),
    .pat_idx   (pat_idx),
    .signature (signature)
`ifdef SIG_COMPARE_EN
    ,
    .exp_sig   (exp_sig),
    .pass      (pass),
    .fail      (fail)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // Behavioural model state
  logic [15:0] m_lfsr [0:1023];
  bit          resp_bits [0:1023];
  logic [15:0] sig_pref [0:1024];
  int          t = 0;
  int          m_n = 0;
  int          m_d = 0;
  bit          chk_on = 1'b0;
  logic [15:0] hold_sig = '0;
  logic [9:0]  hold_pat = '0;
  int          done_seen_t = -1;
  int          done_cnt = 0;
  logic [3:0]  stim_log [0:15];
  logic [15:0] m_exp = '0;
  bit          hold_pass = 1'b0;
  bit          hold_fail = 1'b0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic logic [15:0] misr_next(input logic [15:0] s, input bit r);
    logic [15:0] n;
    n = s << 1;
    if (s[15]) n = n ^ 16'h002D;
    n[0] = n[0] ^ r;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      logic        e_busy, e_done;
      logic [3:0]  e_stim;
      logic [15:0] e_sig;
      logic [9:0]  e_pat;
      int          s;
      s = t - 1 - RL;
      if (s < 0) s = 0;
      if (s > m_n) s = m_n;
      e_done = 1'b0;
      e_stim = 4'h0;
      e_pat  = (m_n == 0) ? 10'd0 : 10'(m_n - 1);
      e_sig  = sig_pref[s];
      e_busy = 1'b1;
      if (t == 0) begin
        e_busy = 1'b0;
        e_sig  = hold_sig;
        e_pat  = hold_pat;
      end else if (t <= m_n) begin
        e_stim = m_lfsr[t-1][3:0];
        e_pat  = 10'(t - 1);
      end else if (t == m_d) begin
        e_done = 1'b1;
      end else if (t > m_d) begin
        e_busy = 1'b0;
      end
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("stim_out", stim_out, e_stim);
      chk("pat_idx", pat_idx, e_pat);
      chk("signature", signature, e_sig);
`ifdef SIG_COMPARE_EN
      if (t == 0) begin
        chk("pass", pass, hold_pass);
        chk("fail", fail, hold_fail);
      end else if (t < m_d) begin
        chk("pass", pass, 1'b0);
        chk("fail", fail, 1'b0);
      end else begin
        chk("pass", pass, sig_pref[m_n] == m_exp);
        chk("fail", fail, sig_pref[m_n] != m_exp);
      end
`endif
      if (t >= 1 && t <= 16) stim_log[t-1] = stim_out;
      if (done) begin
        done_cnt++;
        if (done_seen_t < 0) done_seen_t = t;
      end
    end
  end

  task automatic fill_resp(input int mode);
    for (int k = 0; k < 1024; k++) resp_bits[k] = (mode == 2) ? bit'($urandom % 2) : bit'(mode);
  endtask

  // Entered and left one time unit after a rising edge.
  task automatic do_run(input int n, input int abort_t, input bit spam, input bit junk_rand,
                        input logic [15:0] exp_val);
    bit junk;
    m_lfsr[0] = 16'hACE1;
    for (int k = 1; k < 1024; k++) m_lfsr[k] = lfsr_next(m_lfsr[k-1]);
    sig_pref[0] = '0;
    for (int k = 0; k < n; k++) sig_pref[k+1] = misr_next(sig_pref[k], resp_bits[k]);
    m_n = n;
    m_d = (n == 0) ? 2 : n + RL + 2;
    m_exp = exp_val;
    done_seen_t = -1;
    done_cnt = 0;
    t = 0;
    num_pat = 10'(n);
    start = 1'b1;
`ifdef SIG_COMPARE_EN
    exp_sig = exp_val;
`endif
    junk = junk_rand ? bit'($urandom % 2) : 1'b1;
    resp_in = junk;
    chk_on = 1'b1;
    for (int c = 1; c <= m_d + 1; c++) begin
      int k;
      @(posedge clk);
      #1;
      t = c;
      if (c == abort_t) begin
        chk_on = 1'b0;
        chk("pat_before_reset", pat_idx, 10'(c - 1));
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_sig", signature, 16'h0);
        chk("rst_stim", stim_out, 4'h0);
        chk("rst_pat", pat_idx, 10'h0);
        chk("rst_done", done, 1'b0);
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold_sig = '0;
        hold_pat = '0;
        hold_pass = 1'b0;
        hold_fail = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      start = spam && (c <= m_d) && ((c % 3 == 0) || (c == m_d));
      k = c - 1 - RL;
      if (junk_rand) junk = bit'($urandom % 2);
      resp_in = (k >= 0 && k < n) ? resp_bits[k] : junk;
    end
    start = 1'b0;
    @(negedge clk);
    #1;
    chk_on = 1'b0;
    chk("done_count", done_cnt, 1);
    hold_sig = sig_pref[n];
    hold_pat = (n == 0) ? 10'd0 : 10'(n - 1);
    hold_pass = (sig_pref[n] == exp_val);
    hold_fail = (sig_pref[n] != exp_val);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0d actual=timeout required=finish", t);
    failed++;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_stim", stim_out, 4'h0);
    chk("reset_sig", signature, 16'h0);
    chk("reset_pat", pat_idx, 10'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    fill_resp(1);
    do_run(0, -1, 1'b0, 1'b0, 16'h0000);
    chk("n0_done_at", done_seen_t, 2);
    chk("n0_sig", signature, 16'h0000);

    fill_resp(1);
    do_run(1, -1, 1'b0, 1'b0, 16'h0001);
    chk("n1_stim0", stim_log[0], 4'h1);
    chk("n1_sig", signature, 16'h0001);

    fill_resp(0);
    do_run(5, -1, 1'b0, 1'b0, 16'h0000);
    chk("n5_stim0", stim_log[0], 4'h1);
    chk("n5_stim1", stim_log[1], 4'h0);
    chk("n5_stim2", stim_log[2], 4'h8);
    chk("n5_stim3", stim_log[3], 4'hC);
    chk("n5_stim4", stim_log[4], 4'hE);
    chk("n5_done_at", done_seen_t, 8);
    chk("n5_sig", signature, 16'h0000);

    fill_resp(1);
    do_run(2, -1, 1'b0, 1'b0, 16'h0003);
    chk("n2_ones_sig", signature, 16'h0003);

    fill_resp(2);
    do_run(100, 38, 1'b0, 1'b1, 16'h0000);

    fill_resp(2);
    do_run(20, -1, 1'b1, 1'b1, 16'h0000);
    chk("spam_pat_end", pat_idx, 10'd19);
    chk("spam_done_once", done_cnt, 1);

    fill_resp(2);
    do_run(37, -1, 1'b0, 1'b1, 16'h0000);

    fill_resp(2);
    do_run(1023, -1, 1'b0, 1'b1, 16'h0000);
    chk("max_pat_end", pat_idx, 10'd1022);

`ifdef SIG_COMPARE_EN
    begin
      logic [15:0] golden;
      fill_resp(2);
      golden = '0;
      for (int k = 0; k < 12; k++) golden = misr_next(golden, resp_bits[k]);
      do_run(12, -1, 1'b0, 1'b1, golden);
      chk("cmp_pass", pass, 1'b1);
      chk("cmp_fail", fail, 1'b0);
      resp_bits[5] = ~resp_bits[5];
      do_run(12, -1, 1'b0, 1'b1, golden);
      chk("cmp_pass_flip", pass, 1'b0);
      chk("cmp_fail_flip", fail, 1'b1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
